// File: rtl/forwarded_clock_tx_pkg.sv
// rtl/forwarded_clock_tx_pkg.sv - shared types and widths for the forwarded clock transmitter
package fwd_clk_pkg;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    localparam int CNT_W  = $clog2(256);
    localparam int HOLD_W = 8;

    // (cnt - ph) mod div, for cnt and ph both already below div
    function automatic logic [CNT_W-1:0] phase_diff(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] ph,
        input logic [CNT_W:0]   div
    );
        logic [CNT_W:0] diff;
        if (cnt >= ph)
            diff = {1'b0, cnt} - {1'b0, ph};
        else
            diff = {1'b0, cnt} + div - {1'b0, ph};
        return diff[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/forwarded_clock_tx_if.sv
// rtl/forwarded_clock_tx_if.sv - control and DDR-data bundle of the forwarded clock transmitter
interface forwarded_clock_tx_if;

    logic       enable_i;
    logic [7:0] phase_i;
    logic       half_i;
    logic       oddr_d1_o;
    logic       oddr_d2_o;
    logic       sync_o;
    logic       running_o;
    logic       stopped_o;

    modport master (
        output enable_i, phase_i, half_i,
        input  oddr_d1_o, oddr_d2_o, sync_o, running_o, stopped_o
    );

    modport slave (
        input  enable_i, phase_i, half_i,
        output oddr_d1_o, oddr_d2_o, sync_o, running_o, stopped_o
    );

endinterface

// File: rtl/forwarded_clock_oddr.sv
// rtl/forwarded_clock_oddr.sv - DDR output stage and pin buffer for the forwarded clock
module forwarded_clock_oddr #(
    parameter string DEVICE   = "7SERIES",
    parameter bit    DIFF_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d1,
    input  logic d2,
    output logic pin_p,
    output logic pin_n
);

    logic d1_r;
    logic d2_r;
    logic d2_f;
    logic q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_r <= 1'b0;
            d2_r <= 1'b0;
        end else begin
            d1_r <= d1;
            d2_r <= d2;
        end
    end

    generate
        if (DEVICE == "SPARTAN6") begin : g_oddr2
            // ODDR2 with C0 alignment: second phase clocked by the inverted clock
            logic clk_n;
            assign clk_n = ~clk;
            always_ff @(posedge clk_n or negedge rst_n) begin
                if (!rst_n) d2_f <= 1'b0;
                else        d2_f <= d2_r;
            end
        end else begin : g_oddr
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) d2_f <= 1'b0;
                else        d2_f <= d2_r;
            end
        end
    endgenerate

    assign q = clk ? d1_r : d2_f;

    generate
        if (DIFF_OUT) begin : g_obufds
            assign pin_p = q;
            assign pin_n = ~q;
        end else begin : g_obuf
            assign pin_p = q;
            assign pin_n = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/forwarded_clock_tx_core.sv
// rtl/forwarded_clock_tx_core.sv - reference counter and start/stop FSM producing registered D1/D2 and sync
module forwarded_clock_tx_core
    import fwd_clk_pkg::*;
#(
    parameter int DIV       = 4,
    parameter int STOP_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic [7:0] phase_i,
    input  logic       half_i,
    output logic       oddr_d1_o,
    output logic       oddr_d2_o,
    output logic       sync_o,
    output logic       running_o,
    output logic       stopped_o
);

    localparam logic [CNT_W:0]    DIV_W     = (CNT_W+1)'(DIV);
    localparam logic [CNT_W-1:0]  LAST      = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  HALF      = CNT_W'(DIV / 2);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STOP_HOLD - 1);

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    ref_cnt;
    logic [CNT_W-1:0]    ph_q;
    logic [CNT_W-1:0]    ph_mod;
    logic [CNT_W-1:0]    pos;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                half_q;
    logic                lvl;
    logic                lvl_q;
    logic                capture;

    assign ph_mod = CNT_W'({1'b0, phase_i} % DIV_W);
    assign pos    = phase_diff(ref_cnt, ph_q, DIV_W);

    always_comb begin
        state_nx = state;
        lvl      = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i) begin
                    capture  = 1'b1;
                    state_nx = ARM;
                end
            end
            // leave ARM on the last count so RUN opens on pos 0
            ARM: begin
                if (!enable_i)
                    state_nx = IDLE;
                else if (pos == LAST)
                    state_nx = RUN;
            end
            RUN: begin
                lvl = (pos < HALF);
                if (!enable_i && pos == HALF_LAST)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (hold_cnt == HOLD_LAST)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ref_cnt   <= '0;
            hold_cnt  <= '0;
            ph_q      <= '0;
            half_q    <= 1'b0;
            lvl_q     <= 1'b0;
            oddr_d1_o <= 1'b0;
            oddr_d2_o <= 1'b0;
            sync_o    <= 1'b0;
            running_o <= 1'b0;
            stopped_o <= 1'b1;
        end else begin
            state    <= state_nx;
            ref_cnt  <= (ref_cnt == LAST) ? '0 : ref_cnt + 1'b1;
            hold_cnt <= (state == DRAIN && state_nx == DRAIN) ? hold_cnt + 1'b1 : '0;
            if (capture) begin
                ph_q   <= ph_mod;
                half_q <= half_i;
            end
            lvl_q     <= lvl;
            // half-cycle delay: D1 carries last cycle's level, D2 the current one
            oddr_d1_o <= half_q ? lvl_q : lvl;
            oddr_d2_o <= lvl;
            sync_o    <= (state == RUN) && (pos == '0);
            running_o <= (state == RUN);
            stopped_o <= (state == IDLE);
        end
    end

endmodule

// File: rtl/forwarded_clock_tx.sv
// rtl/forwarded_clock_tx.sv - forwarded clock transmitter top: core FSM plus DDR pin stage
module forwarded_clock_tx #(
    parameter int    DIV       = 4,
    parameter int    STOP_HOLD = 16,
    parameter string DEVICE    = "7SERIES",
    parameter bit    DIFF_OUT  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    forwarded_clock_tx_if.slave  bus,
    output logic                 fwd_clk_p,
    output logic                 fwd_clk_n
);

    logic d1;
    logic d2;

    forwarded_clock_tx_core #(
        .DIV       (DIV),
        .STOP_HOLD (STOP_HOLD)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_i  (bus.enable_i),
        .phase_i   (bus.phase_i),
        .half_i    (bus.half_i),
        .oddr_d1_o (d1),
        .oddr_d2_o (d2),
        .sync_o    (bus.sync_o),
        .running_o (bus.running_o),
        .stopped_o (bus.stopped_o)
    );

    assign bus.oddr_d1_o = d1;
    assign bus.oddr_d2_o = d2;

    forwarded_clock_oddr #(
        .DEVICE   (DEVICE),
        .DIFF_OUT (DIFF_OUT)
    ) u_oddr (
        .clk   (clk),
        .rst_n (rst_n),
        .d1    (d1),
        .d2    (d2),
        .pin_p (fwd_clk_p),
        .pin_n (fwd_clk_n)
    );

endmodule

// File: tb/tb_forwarded_clock_tx.sv
// tb/tb_forwarded_clock_tx.sv - vector-table bench for forwarded_clock_tx (DIV=4 and DIV=2 instances)
module tb_forwarded_clock_tx;

    logic clk = 1'b0;
    logic rst_n;
    logic p1, n1, p2, n2;

    forwarded_clock_tx_if bus1 ();
    forwarded_clock_tx_if bus2 ();

    forwarded_clock_tx #(.DIV(4), .STOP_HOLD(16), .DEVICE("7SERIES"), .DIFF_OUT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .fwd_clk_p(p1), .fwd_clk_n(n1));

    forwarded_clock_tx #(.DIV(2), .STOP_HOLD(1), .DEVICE("SPARTAN6"), .DIFF_OUT(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .fwd_clk_p(p2), .fwd_clk_n(n2));

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         tgt;
        logic       en;
        logic [7:0] ph;
        logic       hf;
        logic [4:0] want;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic drive(input logic en, input logic [7:0] ph, input logic hf);
        bus1.enable_i = en; bus1.phase_i = ph; bus1.half_i = hf;
        bus2.enable_i = en; bus2.phase_i = ph; bus2.half_i = hf;
    endtask

    function automatic logic [4:0] outs(input bit tgt);
        if (tgt)
            return {bus2.oddr_d1_o, bus2.oddr_d2_o, bus2.sync_o, bus2.running_o, bus2.stopped_o};
        return {bus1.oddr_d1_o, bus1.oddr_d2_o, bus1.sync_o, bus1.running_o, bus1.stopped_o};
    endfunction

    task automatic add(input string tag, input bit tgt, input logic en, input logic [7:0] ph,
                       input logic hf, input logic d1, input logic d2, input logic sy,
                       input logic ru, input logic st);
        vec_t v;
        v.tag = tag; v.tgt = tgt; v.en = en; v.ph = ph; v.hf = hf;
        v.want = {d1, d2, sy, ru, st};
        vecs.push_back(v);
    endtask

    task automatic check(input string tag, input int idx, input logic [4:0] act, input logic [4:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s[%0d]: {d1,d2,sync,run,stop} got %b expected %b", tag, idx, act, want);
        end
    endtask

    task automatic check_bit(input string tag, input int idx, input logic act, input logic want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %b expected %b", tag, idx, act, want);
        end
    endtask

    // inputs go in just after a rising edge; the DUT's answer is read on the falling edge
    task automatic run_vecs();
        vec_t e;
        logic prev_d1;
        logic pin;
        prev_d1 = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            pin = vecs[i].tgt ? p2 : p1;
            check_bit("pin_high_phase", i, pin, prev_d1);
            drive(vecs[i].en, vecs[i].ph, vecs[i].hf);
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            check(e.tag, i, outs(e.tgt), e.want);
            prev_d1 = e.want[4];
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic bd(input int i);
        return (i >= 4) && ((i % 4) < 2);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_div4", 0, outs(1'b0), 5'b00001);
        check("reset_div2", 0, outs(1'b1), 5'b00001);
        check_bit("reset_pin", 0, p1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // DIV=4 phase 0: start, steady run, stop at pos 0, re-enable ignored in DRAIN
        for (int i = 1; i <= 34; i++) begin
            logic en, lv, sy;
            en = (i <= 11) || (i == 20) || (i == 21);
            lv = ((i - 1) % 4) < 2;
            sy = ((i - 1) % 4) == 0;
            if (i <= 2)       add("idle_a",  0, en, 8'd0, 1'b0, 0, 0, 0, 0, 1);
            else if (i <= 4)  add("arm_a",   0, en, 8'd0, 1'b0, 0, 0, 0, 0, 0);
            else if (i <= 14) add("run_a",   0, en, 8'd0, 1'b0, lv, lv, sy, 1, 0);
            else if (i <= 30) add("drain_a", 0, en, 8'd0, 1'b0, 0, 0, 0, 0, 0);
            else              add("stop_a",  0, en, 8'd0, 1'b0, 0, 0, 0, 0, 1);
        end
        run_vecs();

        // phase 3: edges three cycles later than phase 0
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            if (i <= 2)       add("idle_b", 0, 1'b1, 8'd3, 1'b0, 0, 0, 0, 0, 1);
            else if (i == 3)  add("arm_b",  0, 1'b1, 8'd3, 1'b0, 0, 0, 0, 0, 0);
            else              add("run_b",  0, 1'b1, 8'd3, 1'b0, bd(i), bd(i), (i % 4) == 0, 1, 0);
        end
        run_vecs();

        // half cycle, phase 7 (== 3 mod 4); later phase/half changes must be ignored
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] ph;
            logic       hf;
            ph = (i < 10) ? 8'd7 : 8'd0;
            hf = (i < 10);
            if (i <= 2)       add("idle_c", 0, 1'b1, ph, hf, 0, 0, 0, 0, 1);
            else if (i == 3)  add("arm_c",  0, 1'b1, ph, hf, 0, 0, 0, 0, 0);
            else              add("run_c",  0, 1'b1, ph, hf, bd(i - 1), bd(i), (i % 4) == 0, 1, 0);
        end
        run_vecs();

        // one-cycle enable: ARM aborts back to IDLE with no toggle
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) add("abort_e", 0, i == 1, 8'd0, 1'b0, 0, 0, 0, 0, 0);
            else        add("abort_e", 0, i == 1, 8'd0, 1'b0, 0, 0, 0, 0, 1);
        end
        run_vecs();

        // DIV=2, STOP_HOLD=1: clk/2 output, single-cycle drain
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            logic en, lv;
            en = (i <= 8);
            lv = (i % 2) == 1;
            if (i <= 2)       add("idle_d2",  1, en, 8'd0, 1'b0, 0, 0, 0, 0, 1);
            else if (i <= 4)  add("arm_d2",   1, en, 8'd0, 1'b0, 0, 0, 0, 0, 0);
            else if (i <= 11) add("run_d2",   1, en, 8'd0, 1'b0, lv, lv, lv, 1, 0);
            else if (i == 12) add("drain_d2", 1, en, 8'd0, 1'b0, 0, 0, 0, 0, 0);
            else              add("stop_d2",  1, en, 8'd0, 1'b0, 0, 0, 0, 0, 1);
        end
        run_vecs();

        // asynchronous reset in the middle of a high phase
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            if (i <= 2)      add("pre_f", 0, 1'b1, 8'd0, 1'b0, 0, 0, 0, 0, 1);
            else if (i <= 4) add("pre_f", 0, 1'b1, 8'd0, 1'b0, 0, 0, 0, 0, 0);
            else             add("pre_f", 0, 1'b1, 8'd0, 1'b0, 1, 1, 1, 1, 0);
        end
        run_vecs();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 0, outs(1'b0), 5'b00001);
        check_bit("async_rst_pin", 0, p1, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_rst", 0, outs(1'b0), 5'b00001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
